// File: rtl/nq_pipelined_multiplier_if.sv
// -----------------------------------------------------------------------------
// nq_pipelined_multiplier_if
//   Handshake bundle for the signed-magnitude Nq multiplier.
//   Ingress : ing_valid / ing_ready, ing_multiplicand, ing_multiplier
//   Egress  : egr_valid / egr_ready, egr_product, egr_overflow
//   Status  : cmd_clear_overflow (pulse in), sr_overflow_sticky (out)
//   The master modport is the producer/consumer side (e.g. a testbench or the
//   surrounding datapath). The slave modport is the multiplier itself.
// -----------------------------------------------------------------------------
interface nq_pipelined_multiplier_if #(
  parameter int N_BITS_P = 32
);
  logic                ing_valid;
  logic                ing_ready;
  logic [N_BITS_P-1:0] ing_multiplicand;
  logic [N_BITS_P-1:0] ing_multiplier;
  logic                egr_valid;
  logic                egr_ready;
  logic [N_BITS_P-1:0] egr_product;
  logic                egr_overflow;
  logic                cmd_clear_overflow;
  logic                sr_overflow_sticky;

  modport master (
    output ing_valid, ing_multiplicand, ing_multiplier, egr_ready, cmd_clear_overflow,
    input  ing_ready, egr_valid, egr_product, egr_overflow, sr_overflow_sticky
  );

  modport slave (
    input  ing_valid, ing_multiplicand, ing_multiplier, egr_ready, cmd_clear_overflow,
    output ing_ready, egr_valid, egr_product, egr_overflow, sr_overflow_sticky
  );
endinterface

// File: rtl/nq_pipelined_multiplier.sv
// -----------------------------------------------------------------------------
// nq_pipelined_multiplier
//   Signed-magnitude Nq fixed-point multiplier with valid/ready flow control,
//   optional round-half-up and optional saturation.
//   Word format: MSB = sign, low N_BITS_P-1 bits = magnitude with Q_BITS_P
//   fractional bits.
//
//   Ports:
//     clk    clock
//     rst_n  asynchronous reset, active-low
//     bus    nq_pipelined_multiplier_if.slave (ingress, egress, sticky status)
//
//   Structure: an operand capture register (loaded on the accepting edge)
//   feeds the arithmetic; its result then walks through PIPE_STAGES_P result
//   stages, the last of which drives the egress port. A sample accepted on
//   edge k is therefore presented on egress after edge k+PIPE_STAGES_P.
//   All registers advance together (global stall) whenever the egress stage
//   is empty or being drained.
// -----------------------------------------------------------------------------
module nq_pipelined_multiplier #(
  parameter int N_BITS_P      = 32,
  parameter int Q_BITS_P      = 15,
  parameter int PIPE_STAGES_P = 3,
  parameter int ROUND_P       = 1,
  parameter int SATURATE_P    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nq_pipelined_multiplier_if.slave  bus
);

  localparam int M_C         = N_BITS_P - 1;   // magnitude width
  localparam int PW_C        = 2 * M_C + 1;    // full product plus rounding carry
  localparam int RND_SHIFT_C = (Q_BITS_P > 0) ? (Q_BITS_P - 1) : 0;
  localparam logic [PW_C-1:0] RND_C =
    ((ROUND_P != 0) && (Q_BITS_P > 0)) ? (PW_C'(1) << RND_SHIFT_C) : '0;

  // Returns {overflow, sign, magnitude} for one operand pair.
  function automatic logic [N_BITS_P:0] nq_mul(
    input logic [N_BITS_P-1:0] a,
    input logic [N_BITS_P-1:0] b
  );
    logic [PW_C-1:0] prod_v;
    logic [PW_C-1:0] res_v;
    logic [M_C-1:0]  mag_v;
    logic            ovf_v;
    logic            sign_v;
    prod_v = PW_C'(a[M_C-1:0]) * PW_C'(b[M_C-1:0]);
    // (2^M-1)^2 + 2^(Q-1) always fits in 2M+1 bits, so the carry is never lost.
    prod_v = prod_v + RND_C;
    res_v  = prod_v >> Q_BITS_P;
    ovf_v  = |res_v[PW_C-1:M_C];
    if ((SATURATE_P != 0) && ovf_v) begin
      mag_v = '1;
    end else begin
      mag_v = res_v[M_C-1:0];
    end
    // A zero magnitude is always reported as +0.
    sign_v = (a[N_BITS_P-1] ^ b[N_BITS_P-1]) & (|mag_v);
    return {ovf_v, sign_v, mag_v};
  endfunction

  logic                      advance_s;
  logic [N_BITS_P:0]         op_result_s;

  logic                      op_valid_r;
  logic [N_BITS_P-1:0]       op_a_r;
  logic [N_BITS_P-1:0]       op_b_r;

  logic [PIPE_STAGES_P-1:0]  st_valid_r;
  logic [PIPE_STAGES_P-1:0]  st_ovf_r;
  logic [N_BITS_P-1:0]       st_prod_r [PIPE_STAGES_P];

  logic                      sticky_r;

  // The whole pipeline moves only when the egress slot is free or draining.
  assign advance_s   = !st_valid_r[PIPE_STAGES_P-1] || bus.egr_ready;
  assign bus.ing_ready = advance_s;

  assign op_result_s = nq_mul(op_a_r, op_b_r);

  assign bus.egr_valid          = st_valid_r[PIPE_STAGES_P-1];
  assign bus.egr_product        = st_prod_r[PIPE_STAGES_P-1];
  assign bus.egr_overflow       = st_ovf_r[PIPE_STAGES_P-1];
  assign bus.sr_overflow_sticky = sticky_r;

  // Operand capture: data is only loaded for real samples so bubbles keep the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_r <= 1'b0;
      op_a_r     <= '0;
      op_b_r     <= '0;
    end else if (advance_s) begin
      op_valid_r <= bus.ing_valid;
      if (bus.ing_valid) begin
        op_a_r <= bus.ing_multiplicand;
        op_b_r <= bus.ing_multiplier;
      end
    end
  end

  // Result stages: stage 0 takes the arithmetic result, later stages shift it along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_r <= '0;
      st_ovf_r   <= '0;
      for (int i = 0; i < PIPE_STAGES_P; i++) begin
        st_prod_r[i] <= '0;
      end
    end else if (advance_s) begin
      st_valid_r[0] <= op_valid_r;
      if (op_valid_r) begin
        st_prod_r[0] <= op_result_s[N_BITS_P-1:0];
        st_ovf_r[0]  <= op_result_s[N_BITS_P];
      end
      for (int i = 1; i < PIPE_STAGES_P; i++) begin
        st_valid_r[i] <= st_valid_r[i-1];
        if (st_valid_r[i-1]) begin
          st_prod_r[i] <= st_prod_r[i-1];
          st_ovf_r[i]  <= st_ovf_r[i-1];
        end
      end
    end
  end

  // Sticky overflow: an overflowing egress transfer wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
    end else if (bus.egr_valid && bus.egr_ready && bus.egr_overflow) begin
      sticky_r <= 1'b1;
    end else if (bus.cmd_clear_overflow) begin
      sticky_r <= 1'b0;
    end else begin
      sticky_r <= sticky_r;
    end
  end

endmodule

// File: tb/tb_nq_pipelined_multiplier.sv
// -----------------------------------------------------------------------------
// tb_nq_pipelined_multiplier
//   Directed bench for nq_pipelined_multiplier. Three instances share the same
//   stimulus: the default build, a wrap (no saturation) build and a truncating
//   (no rounding) build. Inputs are driven and outputs sampled on the falling
//   edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_nq_pipelined_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nq_pipelined_multiplier_if #(.N_BITS_P(32)) ifm ();
  nq_pipelined_multiplier_if #(.N_BITS_P(32)) ifs ();
  nq_pipelined_multiplier_if #(.N_BITS_P(32)) ifr ();

  assign ifs.ing_valid          = ifm.ing_valid;
  assign ifs.ing_multiplicand   = ifm.ing_multiplicand;
  assign ifs.ing_multiplier     = ifm.ing_multiplier;
  assign ifs.egr_ready          = ifm.egr_ready;
  assign ifs.cmd_clear_overflow = ifm.cmd_clear_overflow;
  assign ifr.ing_valid          = ifm.ing_valid;
  assign ifr.ing_multiplicand   = ifm.ing_multiplicand;
  assign ifr.ing_multiplier     = ifm.ing_multiplier;
  assign ifr.egr_ready          = ifm.egr_ready;
  assign ifr.cmd_clear_overflow = ifm.cmd_clear_overflow;

  nq_pipelined_multiplier #(.N_BITS_P(32), .Q_BITS_P(15), .PIPE_STAGES_P(3),
                            .ROUND_P(1), .SATURATE_P(1))
    dut_m (.clk(clk), .rst_n(rst_n), .bus(ifm));
  nq_pipelined_multiplier #(.N_BITS_P(32), .Q_BITS_P(15), .PIPE_STAGES_P(3),
                            .ROUND_P(1), .SATURATE_P(0))
    dut_ns (.clk(clk), .rst_n(rst_n), .bus(ifs));
  nq_pipelined_multiplier #(.N_BITS_P(32), .Q_BITS_P(15), .PIPE_STAGES_P(3),
                            .ROUND_P(0), .SATURATE_P(1))
    dut_nr (.clk(clk), .rst_n(rst_n), .bus(ifr));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: N=32, Q=15. Returns {ovf, sign, magnitude}.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input bit rnd, input bit sat);
    logic [63:0] p;
    logic [30:0] mag;
    logic        ovf;
    logic        sgn;
    p   = {33'd0, a[30:0]} * {33'd0, b[30:0]};
    if (rnd) p = p + 64'd16384;
    p   = p >> 15;
    ovf = (p >= 64'h0000_0000_8000_0000);
    mag = (sat && ovf) ? 31'h7FFF_FFFF : p[30:0];
    sgn = (a[31] ^ b[31]) && (mag != 31'd0);
    return {ovf, sgn, mag};
  endfunction

  // One isolated transaction; lat counts rising edges after the accepting edge.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_m, input logic [31:0] exp_ns,
                         input logic [31:0] exp_nr, input logic exp_ovf,
                         input bit pulse_clear, output int lat);
    ifm.ing_valid        = 1'b1;
    ifm.ing_multiplicand = a;
    ifm.ing_multiplier   = b;
    #1;
    check({tag, "_ing_ready"}, {31'd0, ifm.ing_ready}, 32'd1);
    @(negedge clk);
    ifm.ing_valid = 1'b0;
    lat = 0;
    while (!ifm.egr_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_egr_valid"}, {31'd0, ifm.egr_valid}, 32'd1);
    check({tag, "_prod"},      ifm.egr_product, exp_m);
    check({tag, "_prod_wrap"}, ifs.egr_product, exp_ns);
    check({tag, "_prod_trunc"}, ifr.egr_product, exp_nr);
    check({tag, "_ovf"},       {31'd0, ifm.egr_overflow}, {31'd0, exp_ovf});
    check({tag, "_ovf_wrap"},  {31'd0, ifs.egr_overflow}, {31'd0, exp_ovf});
    if (pulse_clear) ifm.cmd_clear_overflow = 1'b1;
    @(negedge clk);
    ifm.cmd_clear_overflow = 1'b0;
    check({tag, "_drained"}, {31'd0, ifm.egr_valid}, 32'd0);
  endtask

  logic [31:0] sa [20];
  logic [31:0] sb [20];
  logic [32:0] expq [$];
  logic [32:0] exp_v;
  logic [31:0] held_prod;
  logic        held_ovf;
  bit          held_v;
  int          sent;
  int          got;
  int          lat;

  initial begin
    rst_n                  = 1'b0;
    ifm.ing_valid          = 1'b0;
    ifm.ing_multiplicand   = 32'd0;
    ifm.ing_multiplier     = 32'd0;
    ifm.egr_ready          = 1'b1;
    ifm.cmd_clear_overflow = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_egr_valid", {31'd0, ifm.egr_valid}, 32'd0);
    check("rst_prod",      ifm.egr_product, 32'd0);
    check("rst_ovf",       {31'd0, ifm.egr_overflow}, 32'd0);
    check("rst_sticky",    {31'd0, ifm.sr_overflow_sticky}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ing_ready", {31'd0, ifm.ing_ready}, 32'd1);

    // 1.0 * 1.0 and latency
    run_one("t1", 32'h0000_8000, 32'h0000_8000,
            32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, lat);
    check("t1_latency", 32'(lat), 32'd3);

    // -1.5 * 2.0
    run_one("t2", 32'h8000_C000, 32'h0001_0000,
            32'h8001_8000, 32'h8001_8000, 32'h8001_8000, 1'b0, 1'b0, lat);
    check("t2_sticky_clear", {31'd0, ifm.sr_overflow_sticky}, 32'd0);

    // Overflow, with a clear on the same edge as the overflowing transfer
    run_one("t3", 32'h4000_0000, 32'h0001_0000,
            32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, lat);
    check("t3_sticky_set_wins", {31'd0, ifm.sr_overflow_sticky}, 32'd1);
    ifm.cmd_clear_overflow = 1'b1;
    @(negedge clk);
    ifm.cmd_clear_overflow = 1'b0;
    check("t3_sticky_cleared", {31'd0, ifm.sr_overflow_sticky}, 32'd0);

    // Half-LSB rounding and no negative zero
    run_one("t4a", 32'h0000_0001, 32'h0000_4000,
            32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, lat);
    run_one("t4b", 32'h8000_0001, 32'h0000_0001,
            32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, lat);

    // Streaming with a 5-cycle egress stall
    for (int i = 0; i < 20; i++) begin
      sa[i] = $urandom & 32'h800F_FFFF;
      sb[i] = $urandom & 32'h801F_FFFF;
    end
    sa[7] = 32'h0400_0000;
    sb[7] = 32'h8010_0000;   // deliberately overflowing sample
    sent   = 0;
    got    = 0;
    held_v = 1'b0;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        check("t5_hold_prod", ifm.egr_product, held_prod);
        check("t5_hold_ovf",  {31'd0, ifm.egr_overflow}, {31'd0, held_ovf});
      end
      ifm.egr_ready = !(cyc >= 8 && cyc < 13);
      ifm.ing_valid = (sent < 20);
      if (sent < 20) begin
        ifm.ing_multiplicand = sa[sent];
        ifm.ing_multiplier   = sb[sent];
      end
      #1;
      if (cyc >= 8 && cyc < 13) begin
        check("t5_stall_egr_valid", {31'd0, ifm.egr_valid}, 32'd1);
        check("t5_stall_ing_ready", {31'd0, ifm.ing_ready}, 32'd0);
      end
      if (ifm.egr_valid && ifm.egr_ready) begin
        if (expq.size() == 0) begin
          check("t5_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_v = expq.pop_front();
          check("t5_prod", ifm.egr_product, exp_v[31:0]);
          check("t5_ovf",  {31'd0, ifm.egr_overflow}, {31'd0, exp_v[32]});
        end
        got++;
      end
      held_v    = ifm.egr_valid && !ifm.egr_ready;
      held_prod = ifm.egr_product;
      held_ovf  = ifm.egr_overflow;
      if (ifm.ing_valid && ifm.ing_ready) begin
        expq.push_back(ref_mul(sa[sent], sb[sent], 1'b1, 1'b1));
        sent++;
      end
    end
    ifm.ing_valid = 1'b0;
    ifm.egr_ready = 1'b1;
    check("t5_result_count", 32'(got), 32'd20);
    check("t5_sticky_after_ovf", {31'd0, ifm.sr_overflow_sticky}, 32'd1);

    // Reset with three samples in flight
    @(negedge clk);
    ifm.egr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifm.ing_valid        = 1'b1;
      ifm.ing_multiplicand = 32'h0000_8000;
      ifm.ing_multiplier   = 32'h0000_8000;
      #1;
      check("t6_ing_ready", {31'd0, ifm.ing_ready}, 32'd1);
      @(negedge clk);
    end
    ifm.ing_valid = 1'b0;
    @(negedge clk);
    check("t6_pre_egr_valid", {31'd0, ifm.egr_valid}, 32'd1);
    check("t6_pre_prod",      ifm.egr_product, 32'h0000_8000);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_egr_valid", {31'd0, ifm.egr_valid}, 32'd0);
    check("t6_rst_prod",      ifm.egr_product, 32'd0);
    check("t6_rst_ovf",       {31'd0, ifm.egr_overflow}, 32'd0);
    check("t6_rst_sticky",    {31'd0, ifm.sr_overflow_sticky}, 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    ifm.egr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_emit", {31'd0, ifm.egr_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
